score_keeper: RTL
=================

Name: score_keeper

Overview:
- Consumer of the round timer's game_over output; the responder side of the timer handshake.
- Scores one play round: counts hit/miss pulses from the arrow-judging logic and applies a combo multiplier.
- Freezes the score when game_over is seen and keeps a session high score.
- Drives HEX1/HEX0 (current score) and HEX3/HEX2 (high score) with active-low 7-segment patterns.

Parameters:
- COMBO_STEP, 4: consecutive hits needed per multiplier step.
- MAX_MULT, 3: multiplier ceiling, range 1..7.
- MAX_SCORE, 99: saturation value for score, at most 99 for two-digit display.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high; clears all state including high score.
- start  in  1  level; a rising edge begins a new round.
- hit  in  1  level; a rising edge is one successful step.
- miss  in  1  level; a rising edge is one missed step.
- game_over  in  1  level from the round timer; high means time expired.
- score  out  7  current round score, binary 0..MAX_SCORE.
- high_score  out  7  best completed-round score since reset.
- combo  out  4  consecutive-hit count, saturating at 15.
- multiplier  out  3  points awarded by the next hit.
- playing  out  1  high in PLAYING state.
- new_record  out  1  high from DONE entry (if a record was set) until the next start.
- HEX0  out  7  score ones digit, active low.
- HEX1  out  7  score tens digit, active low.
- HEX2  out  7  high_score ones digit, active low.
- HEX3  out  7  high_score tens digit, active low.

Behaviour:
- Interface: one clock, CLOCK_50. Reset is asynchronous and active-high, port named reset.
- start, hit, miss and game_over are synchronous to CLOCK_50. Each of start, hit and miss has a registered previous value; an edge = current & ~previous.
- Edge registers reset to 0. A level held high across reset release therefore produces an edge on the first clock.
- Reset values: state IDLE, score 0, high_score 0, combo 0, playing 0, new_record 0, HEX0..HEX3 = "0" pattern (7'b1000000).
- multiplier is combinational from combo: min(1 + combo/COMBO_STEP, MAX_MULT). Reset value 1.
- States: IDLE, PLAYING, DONE.
- IDLE -> PLAYING on a start edge while game_over = 0. A start edge with game_over = 1 is ignored.
- PLAYING -> DONE on any cycle with game_over = 1.
- DONE -> PLAYING on a start edge while game_over = 0. DONE -> IDLE never; only reset returns to IDLE.
- Entering PLAYING (same clock edge): score <= 0, combo <= 0, new_record <= 0, playing <= 1.
- In PLAYING with game_over = 0, a hit edge (and no miss edge): score <= min(score + multiplier, MAX_SCORE); combo <= min(combo + 1, 15). Uses the multiplier value before the update.
- In PLAYING, a miss edge: combo <= 0, score unchanged.
- Simultaneous hit and miss edge: miss wins (combo 0, no points).
- game_over = 1 in the same cycle as a hit or miss edge: the event is ignored and the state goes to DONE.
- Entering DONE: playing <= 0. If score > high_score, then high_score <= score and new_record <= 1; otherwise both are unchanged. A tie is not a record.
- In IDLE and DONE, hit and miss edges have no effect.
- A start edge while in PLAYING is ignored; there is no mid-round restart.
- Latency: score, combo and state update on the clock edge that samples the input edge. The HEX outputs are registered, so they reflect the new value one cycle later.
- Digits use binary/10 and binary%10 through a fixed 0..9 pattern table. Leading zero is displayed, not blanked.
- Reset asserted mid-round: everything clears immediately, asynchronously, including high_score.

Test Plan:
- Reset, then start pulse with game_over = 0 -> playing = 1 next cycle, score = 0, multiplier = 1, HEX1/HEX0 = 7'b1000000.
- 10 consecutive hit pulses -> per-hit points 1,1,1,1,2,2,2,2,3,3; score = 18, combo = 10, multiplier = 3; HEX1 = 7'b1111001, HEX0 = 7'b0000000 one cycle after the last score update.
- After the above, a miss pulse -> combo = 0, multiplier = 1, score stays 18. Then hit and miss rising in the same cycle -> score 18, combo 0.
- Force combo ≥ 8 with score 97, then a hit -> score saturates at 99. A further hit -> 99.
- Assert game_over with score 18 -> DONE, playing = 0, high_score = 18, new_record = 1, HEX3/HEX2 show 1/8. A hit pulse in the same cycle is not counted. A later hit in DONE leaves score at 18.
- Start while game_over = 1 -> ignored. Drop game_over, then start -> score 0, new_record 0, high_score 18 kept. Next round ends with 12 -> high_score stays 18, new_record 0. Assert reset mid-round -> all outputs return to reset values, high_score = 0.

Source files
------------

// File: rtl/score_keeper.sv
// score_keeper: scores one play round from hit/miss pulses with a combo
// multiplier, freezes the score on game_over and keeps a session high score.
// Current score goes to HEX1/HEX0 and high score to HEX3/HEX2 (active low).
module score_keeper #(
  parameter int unsigned COMBO_STEP = 4,
  parameter int unsigned MAX_MULT   = 3,
  parameter int unsigned MAX_SCORE  = 99
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  input  logic       game_over,
  output logic [6:0] score,
  output logic [6:0] high_score,
  output logic [3:0] combo,
  output logic [2:0] multiplier,
  output logic       playing,
  output logic       new_record,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);

  localparam int unsigned SCORE_W = 7;
  localparam int unsigned COMBO_W = 4;
  localparam int unsigned MULT_W  = 3;
  localparam int unsigned SEG_W   = 7;
  localparam logic [SEG_W-1:0] SEG_ZERO = 7'b1000000;
  localparam logic [COMBO_W-1:0] COMBO_MAX = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 start_q, hit_q, miss_q;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   high_q, high_d;
  logic [COMBO_W-1:0]   combo_q, combo_d;
  logic                 playing_q, playing_d;
  logic                 new_record_q, new_record_d;
  logic [SEG_W-1:0]     hex0_q, hex1_q, hex2_q, hex3_q;

  logic                 start_edge, hit_edge, miss_edge;
  logic [31:0]          mult_raw;
  logic [MULT_W-1:0]    mult;
  logic [31:0]          score_sum;
  logic [SCORE_W-1:0]   score_hit;
  logic [SCORE_W-1:0]   s_tens, s_ones, h_tens, h_ones;

  // Active-low 7-segment pattern for a decimal digit (gfedcba order).
  function automatic logic [SEG_W-1:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign start_edge = start & ~start_q;
  assign hit_edge   = hit & ~hit_q;
  assign miss_edge  = miss & ~miss_q;

  // Points for the next hit: one step per COMBO_STEP hits, capped.
  assign mult_raw = 32'd1 + (32'(combo_q) / COMBO_STEP);
  assign mult     = (mult_raw > MAX_MULT) ? MULT_W'(MAX_MULT) : MULT_W'(mult_raw);

  // Saturating score after a hit.
  assign score_sum = 32'(score_q) + 32'(mult);
  assign score_hit = (score_sum > MAX_SCORE) ? SCORE_W'(MAX_SCORE) : SCORE_W'(score_sum);

  assign s_tens = score_q / 7'd10;
  assign s_ones = score_q % 7'd10;
  assign h_tens = high_q / 7'd10;
  assign h_ones = high_q % 7'd10;

  // Previous-level registers used for rising-edge detection.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      start_q <= start;
      hit_q   <= hit;
      miss_q  <= miss;
    end
  end

  // State and scoring registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      score_q      <= '0;
      high_q       <= '0;
      combo_q      <= '0;
      playing_q    <= 1'b0;
      new_record_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      high_q       <= high_d;
      combo_q      <= combo_d;
      playing_q    <= playing_d;
      new_record_q <= new_record_d;
    end
  end

  // Next-state and scoring decisions.
  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    high_d       = high_q;
    combo_d      = combo_q;
    playing_d    = playing_q;
    new_record_d = new_record_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_edge && !game_over) begin
          state_d      = ST_PLAYING;
          score_d      = '0;
          combo_d      = '0;
          new_record_d = 1'b0;
          playing_d    = 1'b1;
        end
      end
      ST_PLAYING: begin
        if (game_over) begin
          state_d   = ST_DONE;
          playing_d = 1'b0;
          if (score_q > high_q) begin
            high_d       = score_q;
            new_record_d = 1'b1;
          end
        end else if (miss_edge) begin
          combo_d = '0;
        end else if (hit_edge) begin
          score_d = score_hit;
          combo_d = (combo_q == COMBO_MAX) ? COMBO_MAX : combo_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Display registers, one cycle behind the binary values.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      hex0_q <= SEG_ZERO;
      hex1_q <= SEG_ZERO;
      hex2_q <= SEG_ZERO;
      hex3_q <= SEG_ZERO;
    end else begin
      hex0_q <= seg7(4'(s_ones));
      hex1_q <= seg7(4'(s_tens));
      hex2_q <= seg7(4'(h_ones));
      hex3_q <= seg7(4'(h_tens));
    end
  end

  assign score      = score_q;
  assign high_score = high_q;
  assign combo      = combo_q;
  assign multiplier = mult;
  assign playing    = playing_q;
  assign new_record = new_record_q;
  assign HEX0       = hex0_q;
  assign HEX1       = hex1_q;
  assign HEX2       = hex2_q;
  assign HEX3       = hex3_q;

endmodule
